// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Request/result bundle between a sequencing controller and seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int W = 5
);
    logic         start;
    logic [1:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         c;
    logic         busy;
    logic         done;

    modport master (output start, s, a, b, input y, c, busy, done);
    modport slave  (input start, s, a, b, output y, c, busy, done);
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Registered AND/OR/ADD (1 cycle) and shift-add MUL (W cycles) unit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int W = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_alu_if.slave    bus
);

    localparam int             CW          = $clog2(W);
    localparam logic [CW-1:0]  C_LAST      = CW'(W - 1);
    localparam logic [1:0]     C_OP_AND    = 2'd0;
    localparam logic [1:0]     C_OP_OR     = 2'd1;
    localparam logic [1:0]     C_OP_ADD    = 2'd2;
    localparam logic [1:0]     C_OP_MUL    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [2*W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d;
    logic [W-1:0]       y_q, y_d;
    logic               c_q, c_d;

    logic [W:0]         w_sum;
    logic [2*W-1:0]     w_acc_nxt;

    assign w_sum     = {1'b0, a_q} + {1'b0, b_q};
    assign w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            y_q      <= '0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            y_q      <= y_d;
            c_q      <= c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        y_d      = y_q;
        c_d      = c_q;

        case (state_q)
            // Accepting from DONE behaves exactly like accepting from IDLE.
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d     = bus.s;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    state_d  = (bus.s == C_OP_MUL) ? MUL : EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                c_d = 1'b0;
                case (op_q)
                    C_OP_AND: y_d = a_q & b_q;
                    C_OP_OR:  y_d = a_q | b_q;
                    C_OP_ADD: begin
                        y_d = w_sum[W-1:0];
                        c_d = w_sum[W];
                    end
                    default:  y_d = y_q;
                endcase
                state_d = DONE;
            end
            MUL: begin
                acc_d    = w_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    y_d     = w_acc_nxt[W-1:0];
                    c_d     = |w_acc_nxt[2*W-1:W];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.y    = y_q;
    assign bus.c    = c_q;
    assign bus.busy = (state_q == EXEC) || (state_q == MUL);
    assign bus.done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Self-checking bench for seq_alu: vector table, random ops, corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W       = 5;
    localparam int MAXWAIT = 4 * W + 10;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.W(W)) bus ();
    seq_alu #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operand values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] y, output logic c);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned r;
        longint unsigned m = 64'd1 << W;
        case (op)
            2'd0:    r = ua & ub;
            2'd1:    r = ua | ub;
            2'd2:    r = ua + ub;
            default: r = ua * ub;
        endcase
        y = W'(r % m);
        c = (op >= 2'd2) ? (r >= m) : 1'b0;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] y, output logic c,
                          output int lat, output int busy_cyc, output logic busy_at_done);
        @(negedge clk);
        bus.start = 1'b1; bus.s = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.s = 2'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
        lat = 0; busy_cyc = 0;
        while (!bus.done && lat < MAXWAIT) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        y = bus.y; c = bus.c; busy_at_done = bus.busy;
    endtask

    task automatic check_op(input string name, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ey, input logic ec);
        logic [W-1:0] y;
        logic         c, bd;
        int           lat, bc, elat;
        elat = (op == 2'd3) ? W : 1;
        run_op(op, a, b, y, c, lat, bc, bd);
        chk({name, "_y"}, 64'(y), 64'(ey));
        chk({name, "_c"}, 64'(c), 64'(ec));
        chk({name, "_lat"}, 64'(lat), 64'(elat));
        chk({name, "_busycyc"}, 64'(bc), 64'(elat));
        chk({name, "_busy_at_done"}, 64'(bd), 64'd0);
        @(negedge clk);
        chk({name, "_done_width"}, 64'(bus.done), 64'd0);
        chk({name, "_y_held"}, 64'(bus.y), 64'(ey));
    endtask

    always @(negedge clk) begin
        if (!rst && bus.busy && bus.done) begin
            miscompares++;
            $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic [W-1:0]  ey, y_hold, ra, rb;
        logic          ec;
        logic [1:0]    rop;
        logic [1:0]    op_seq[5];
        logic [W-1:0]  a_seq[5], b_seq[5];
        int            lat, cyc, prev, cur, nxt, done_seen;

        tbl[0] = '{op: 2'd0, a: 5'b00101, b: 5'b01010, y: 5'b00000, c: 1'b0};
        tbl[1] = '{op: 2'd1, a: 5'b00101, b: 5'b01010, y: 5'b01111, c: 1'b0};
        tbl[2] = '{op: 2'd2, a: 5'b00101, b: 5'b01010, y: 5'b01111, c: 1'b0};
        tbl[3] = '{op: 2'd2, a: 5'b11111, b: 5'b00001, y: 5'b00000, c: 1'b1};
        tbl[4] = '{op: 2'd3, a: 5'b00101, b: 5'b01010, y: 5'b10010, c: 1'b1};
        tbl[5] = '{op: 2'd3, a: 5'b00011, b: 5'b00100, y: 5'b01100, c: 1'b0};

        rst = 1'b1; bus.start = 1'b0; bus.s = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_y", 64'(bus.y), 64'd0);
        chk("rst_c", 64'(bus.c), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].c);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom); ra = W'($urandom); rb = W'($urandom);
            if (i < 4) begin ra = '1; rb = '1; rop = 2'(i); end
            model(rop, ra, rb, ey, ec);
            check_op($sformatf("rnd%0d", i), rop, ra, rb, ey, ec);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Start pulse during MUL iteration 2 must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.s = 2'd3; bus.a = 5'b00101; bus.b = 5'b01010;
        @(negedge clk);
        bus.start = 1'b0; lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        bus.start = 1'b1; bus.s = 2'd0; bus.a = '1; bus.b = '1;
        @(negedge clk); lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < MAXWAIT) begin @(negedge clk); lat++; end
        chk("ign_lat", 64'(lat), 64'(W));
        chk("ign_y", 64'(bus.y), 64'b10010);
        chk("ign_c", 64'(bus.c), 64'd1);
        @(negedge clk);
        chk("ign_idle_busy", 64'(bus.busy), 64'd0);
        chk("ign_idle_done", 64'(bus.done), 64'd0);

        // Asynchronous reset at MUL iteration 3 discards the operation.
        bus.start = 1'b1; bus.s = 2'd3; bus.a = 5'b00111; bus.b = 5'b00111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_y", 64'(bus.y), 64'd0);
        chk("mrst_c", 64'(bus.c), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("mrst_no_done", 64'(done_seen), 64'd0);
        chk("mrst_y_after", 64'(bus.y), 64'd0);

        // Start held high, alternating ADD/MUL.
        for (int i = 0; i < 5; i++) begin
            op_seq[i] = (i % 2 == 0) ? 2'd2 : 2'd3;
            a_seq[i]  = W'($urandom);
            b_seq[i]  = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.s = op_seq[0]; bus.a = a_seq[0]; bus.b = b_seq[0];
        @(negedge clk);
        y_hold = bus.y; cur = 0; nxt = 1; cyc = 0; prev = 0;
        bus.s = 2'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
        while (cur < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                model(op_seq[cur], a_seq[cur], b_seq[cur], ey, ec);
                chk($sformatf("b2b%0d_y", cur), 64'(bus.y), 64'(ey));
                chk($sformatf("b2b%0d_c", cur), 64'(bus.c), 64'(ec));
                if (cur > 0)
                    chk($sformatf("b2b%0d_spacing", cur), 64'(cyc - prev),
                        64'((op_seq[cur] == 2'd3) ? 6 : 2));
                prev = cyc; y_hold = bus.y; cur++;
                if (nxt < 5) begin
                    bus.s = op_seq[nxt]; bus.a = a_seq[nxt]; bus.b = b_seq[nxt];
                    nxt++;
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                chk($sformatf("b2b_hold_c%0d", cyc), 64'(bus.y), 64'(y_hold));
                chk($sformatf("b2b_busy_c%0d", cyc), 64'(bus.busy), 64'd1);
                bus.s = 2'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
            end
        end
        chk("b2b_completed", 64'(cur), 64'd5);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_idle_done", 64'(bus.done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
